// File: rtl/sram_responder.sv
// sram_responder
//   Unified on-chip memory answering the core's instruction-fetch and
//   data load/store SRAM-style ports. Both ports return read data one cycle
//   after the request. Stores honour per-byte write enables. Accesses outside
//   the mapped window set a sticky error flag.
//
//   Optional build macro: SRAM_ERR_CNT_EN adds a saturating fault counter
//   (err_cnt) and the last faulting address (err_last_addr).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   inst_sram_en/addr        instruction read request (wen/wdata ignored)
//   inst_sram_rdata          registered instruction word
//   data_sram_en/wen/addr    data request, wen==0 is a read
//   data_sram_wdata          store data, byte lanes pre-aligned
//   data_sram_rdata          registered load word
//   err_addr                 sticky out-of-range flag
//   err_cnt, err_last_addr   fault accounting (SRAM_ERR_CNT_EN only)
module sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
`ifdef SRAM_ERR_CNT_EN
  output logic [15:0] err_cnt,
  output logic [31:0] err_last_addr,
`endif
  output logic        err_addr
);

  localparam int HI = ADDR_WIDTH + 2;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] instIdx;
  logic [ADDR_WIDTH-1:0] dataIdx;
  logic instInRange;
  logic dataInRange;
  logic instFault;
  logic dataFault;
  logic dataWrite;

  logic [31:0] instRdata_q, instRdata_d;
  logic [31:0] dataRdata_q, dataRdata_d;
  logic        errAddr_q, errAddr_d;

  // The instruction port is read-only and the byte offset never selects a
  // sub-word, so these inputs are intentionally consumed here only.
  logic unusedInputs;
  assign unusedInputs = ^{inst_sram_wen, inst_sram_wdata,
                          inst_sram_addr[1:0], data_sram_addr[1:0]};

  // Address decode: the upper bits select the window, the middle bits the word.
  assign instIdx     = inst_sram_addr[HI-1:2];
  assign dataIdx     = data_sram_addr[HI-1:2];
  assign instInRange = (inst_sram_addr[31:HI] == BASE_ADDR[31:HI]);
  assign dataInRange = (data_sram_addr[31:HI] == BASE_ADDR[31:HI]);
  assign instFault   = inst_sram_en && !instInRange;
  assign dataFault   = data_sram_en && !dataInRange;
  assign dataWrite   = data_sram_en && dataInRange && (data_sram_wen != 4'h0);

  // Memory array has no reset. A write sampled while rst is high is dropped.
  // The instruction read below samples mem with the pre-edge value, which
  // gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (!rst && dataWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[dataIdx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state for the read registers and the sticky flag. An idle port or a
  // store keeps the previous read data so the core can stall safely.
  always_comb begin
    instRdata_d = instRdata_q;
    dataRdata_d = dataRdata_q;
    errAddr_d   = errAddr_q || instFault || dataFault;
    if (inst_sram_en) begin
      instRdata_d = instInRange ? mem[instIdx] : 32'h0;
    end
    if (data_sram_en && (data_sram_wen == 4'h0)) begin
      dataRdata_d = dataInRange ? mem[dataIdx] : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instRdata_q <= 32'h0;
      dataRdata_q <= 32'h0;
      errAddr_q   <= 1'b0;
    end else begin
      instRdata_q <= instRdata_d;
      dataRdata_q <= dataRdata_d;
      errAddr_q   <= errAddr_d;
    end
  end

  assign inst_sram_rdata = instRdata_q;
  assign data_sram_rdata = dataRdata_q;
  assign err_addr        = errAddr_q;

`ifdef SRAM_ERR_CNT_EN
  logic [15:0] errCnt_q, errCnt_d;
  logic [31:0] errLast_q, errLast_d;
  logic [1:0]  faultCount;

  assign faultCount = {1'b0, instFault} + {1'b0, dataFault};

  // Counter adds one per faulting port and sticks at all-ones. The data port
  // address wins when both ports fault together.
  always_comb begin
    errCnt_d  = errCnt_q;
    errLast_d = errLast_q;
    if (errCnt_q > (16'hFFFF - {14'h0, faultCount})) begin
      errCnt_d = 16'hFFFF;
    end else begin
      errCnt_d = errCnt_q + {14'h0, faultCount};
    end
    if (dataFault) begin
      errLast_d = data_sram_addr;
    end else if (instFault) begin
      errLast_d = inst_sram_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCnt_q  <= 16'h0;
      errLast_q <= 32'h0;
    end else begin
      errCnt_q  <= errCnt_d;
      errLast_q <= errLast_d;
    end
  end

  assign err_cnt       = errCnt_q;
  assign err_last_addr = errLast_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Self-checking bench for sram_responder: directed scenarios followed by
//   randomized traffic compared against a word-array reference model.
module tb_sram_responder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        err_addr;
`ifdef SRAM_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [31:0] err_last_addr;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] modelMem [64];
  logic [31:0] expInst;
  logic [31:0] expData;
  logic        expErr;
  int          expCnt;
  logic [31:0] expLast;

  sram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
`ifdef SRAM_ERR_CNT_EN
    .err_cnt         (err_cnt),
    .err_last_addr   (err_last_addr),
`endif
    .err_addr        (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    cycle();
    cycle();
    total++;
    if (inst_sram_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_inst: got %h expected %h", inst_sram_rdata, 32'h0);
    end
    total++;
    if (data_sram_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h expected %h", data_sram_rdata, 32'h0);
    end
    total++;
    if (err_addr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_err: got %b expected 0", err_addr);
    end
`ifdef SRAM_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_cnt: got %h expected 0000", err_cnt);
    end
`endif
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_store_load();
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = BASE + 32'h10;
    data_sram_wdata = 32'h1234_5678;
    cycle();
    data_sram_wen   = 4'h0;
    data_sram_wdata = 32'h0;
    cycle();
    idleInputs();
    total++;
    if (data_sram_rdata !== 32'h1234_5678) begin
      bad++;
      $display("[TB] FAIL store_load: got %h expected %h", data_sram_rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_byte_enable();
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0010;
    data_sram_addr  = BASE + 32'h10;
    data_sram_wdata = 32'h0000_AB00;
    cycle();
    total++;
    if (data_sram_rdata !== 32'h1234_5678) begin
      bad++;
      $display("[TB] FAIL store_holds_rdata: got %h expected %h", data_sram_rdata, 32'h1234_5678);
    end
    data_sram_wen = 4'h0;
    cycle();
    idleInputs();
    total++;
    if (data_sram_rdata !== 32'h1234_AB78) begin
      bad++;
      $display("[TB] FAIL byte_enable: got %h expected %h", data_sram_rdata, 32'h1234_AB78);
    end
  endtask

  task automatic test_hold_idle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++;
      if (data_sram_rdata !== 32'h1234_AB78) begin
        bad++;
        $display("[TB] FAIL hold_idle[%0d]: got %h expected %h", i, data_sram_rdata, 32'h1234_AB78);
      end
    end
  endtask

  task automatic test_collision();
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = BASE + 32'h20;
    data_sram_wdata = 32'h0;
    cycle();
    data_sram_wdata = 32'hDEAD_BEEF;
    inst_sram_en    = 1'b1;
    inst_sram_addr  = BASE + 32'h20;
    cycle();
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    total++;
    if (inst_sram_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL collision_old: got %h expected %h", inst_sram_rdata, 32'h0);
    end
    cycle();
    idleInputs();
    total++;
    if (inst_sram_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL collision_new: got %h expected %h", inst_sram_rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_out_of_range();
    data_sram_en   = 1'b1;
    data_sram_addr = 32'h0000_0000;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h8000_0000;
    cycle();
    idleInputs();
    total++;
    if (data_sram_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_data: got %h expected %h", data_sram_rdata, 32'h0);
    end
    total++;
    if (inst_sram_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_inst: got %h expected %h", inst_sram_rdata, 32'h0);
    end
    total++;
    if (err_addr !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oor_err: got %b expected 1", err_addr);
    end
`ifdef SRAM_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL oor_cnt: got %0d expected 2", err_cnt);
    end
    total++;
    if (err_last_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_last: got %h expected %h", err_last_addr, 32'h0);
    end
`endif
    // err_addr is sticky across idle cycles.
    cycle();
    total++;
    if (err_addr !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oor_sticky: got %b expected 1", err_addr);
    end
  endtask

  task automatic test_async_reset();
    data_sram_en   = 1'b1;
    data_sram_addr = BASE + 32'h10;
    inst_sram_en   = 1'b1;
    inst_sram_addr = BASE + 32'h20;
    cycle();
    idleInputs();
    total++;
    if (data_sram_rdata !== 32'h1234_AB78 || inst_sram_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL pre_reset_read: got %h/%h expected %h/%h",
               data_sram_rdata, inst_sram_rdata, 32'h1234_AB78, 32'hDEAD_BEEF);
    end
    // Raise reset mid-cycle with a store pending; outputs must clear at once.
    #3;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = BASE + 32'h10;
    data_sram_wdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1;
    total++;
    if (data_sram_rdata !== 32'h0 || inst_sram_rdata !== 32'h0 || err_addr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h/%h/%b expected 0/0/0",
               data_sram_rdata, inst_sram_rdata, err_addr);
    end
    cycle();
    rst = 1'b0;
    idleInputs();
`ifdef SRAM_ERR_CNT_EN
    total++;
    if (err_cnt !== 16'h0) begin
      bad++;
      $display("[TB] FAIL async_reset_cnt: got %h expected 0000", err_cnt);
    end
`endif
    data_sram_en   = 1'b1;
    data_sram_addr = BASE + 32'h10;
    cycle();
    idleInputs();
    total++;
    if (data_sram_rdata !== 32'h1234_AB78) begin
      bad++;
      $display("[TB] FAIL write_dropped: got %h expected %h", data_sram_rdata, 32'h1234_AB78);
    end
  endtask

  task automatic test_random();
    logic        iEn, dEn, iOor, dOor;
    int          iIdx, dIdx, faults;
    logic [31:0] iAddr, dAddr, dWdata;
    logic [3:0]  dWen;

    // Give every model word a known value first.
    for (int w = 0; w < 64; w++) begin
      modelMem[w]     = $urandom;
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'hF;
      data_sram_addr  = BASE + 32'(w * 4);
      data_sram_wdata = modelMem[w];
      cycle();
    end
    idleInputs();
    expInst = 32'h0;
    expData = 32'h1234_AB78;
    expErr  = 1'b0;
    expCnt  = 0;
    expLast = 32'h0;

    for (int n = 0; n < 400; n++) begin
      iEn    = 1'($urandom_range(0, 1));
      dEn    = 1'($urandom_range(0, 1));
      iOor   = ($urandom_range(0, 15) == 0);
      dOor   = ($urandom_range(0, 15) == 0);
      iIdx   = $urandom_range(0, 63);
      dIdx   = $urandom_range(0, 63);
      iAddr  = iOor ? ($urandom & 32'h7FFF_FFFF) : BASE + 32'(iIdx * 4) + 32'($urandom_range(0, 3));
      dAddr  = dOor ? ($urandom & 32'h7FFF_FFFF) : BASE + 32'(dIdx * 4) + 32'($urandom_range(0, 3));
      dWen   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      dWdata = $urandom;

      inst_sram_en    = iEn;
      inst_sram_addr  = iAddr;
      inst_sram_wen   = 4'($urandom);
      inst_sram_wdata = $urandom;
      data_sram_en    = dEn;
      data_sram_addr  = dAddr;
      data_sram_wen   = dWen;
      data_sram_wdata = dWdata;

      // Instruction read sees memory before this cycle's store.
      faults = 0;
      if (iEn) begin
        if (iOor) begin
          expInst = 32'h0;
          expErr  = 1'b1;
          expLast = iAddr;
          faults++;
        end else begin
          expInst = modelMem[iIdx];
        end
      end
      if (dEn) begin
        if (dOor) begin
          if (dWen == 4'h0) expData = 32'h0;
          expErr  = 1'b1;
          expLast = dAddr;
          faults++;
        end else if (dWen == 4'h0) begin
          expData = modelMem[dIdx];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (dWen[b]) modelMem[dIdx][8*b +: 8] = dWdata[8*b +: 8];
          end
        end
      end
      expCnt = (expCnt + faults > 65535) ? 65535 : expCnt + faults;

      cycle();
      total++;
      if (inst_sram_rdata !== expInst) begin
        bad++;
        $display("[TB] FAIL rand_inst[%0d]: got %h expected %h", n, inst_sram_rdata, expInst);
      end
      total++;
      if (data_sram_rdata !== expData) begin
        bad++;
        $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, data_sram_rdata, expData);
      end
      total++;
      if (err_addr !== expErr) begin
        bad++;
        $display("[TB] FAIL rand_err[%0d]: got %b expected %b", n, err_addr, expErr);
      end
`ifdef SRAM_ERR_CNT_EN
      total++;
      if (err_cnt !== 16'(expCnt) || err_last_addr !== expLast) begin
        bad++;
        $display("[TB] FAIL rand_cnt[%0d]: got %0d/%h expected %0d/%h",
                 n, err_cnt, err_last_addr, expCnt, expLast);
      end
`endif
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_hold_idle();
    test_collision();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
